id_ex_stage: RTL

ID/EX pipeline register of the five-stage RV64 core, with the load-use hazard detector, EX-stage forwarding selects and a stall counter. It captures decoded operands and control from ID each cycle. It presents `ex_ALUop`, `ex_funct3` and `ex_funct7` to the ALU control decoder, and operands plus forward selects to the EX datapath. It generates the stall and bubble signals for the front end and clears in-flight state on branch flush.

---
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage RV64 core.
// It also contains the load-use hazard detector, the EX-stage forwarding
// selects and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_*                 decoded operands, indices, fields and control from ID
//   flush                branch taken in EX; EX receives a bubble
//   mem_RegWrite/mem_rd  EX/MEM destination, used for forwarding
//   wb_RegWrite/wb_rd    MEM/WB destination, used for forwarding
//   ex_*                 registered copies of the id_* inputs, plus ex_valid
//   forwardA/forwardB    operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall                load-use hazard (suppressed by flush)
//   pc_write/if_id_write front-end enables, low while stalling
//   stall_count          saturating count of stall cycles
module id_ex_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [1:0]      id_ALUop,
  input  logic            id_ALUSrc,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_RegWrite,
  input  logic            id_MemtoReg,
  input  logic            id_Branch,
  input  logic            flush,
  input  logic            mem_RegWrite,
  input  logic [4:0]      mem_rd,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [1:0]      ex_ALUop,
  output logic            ex_ALUSrc,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_RegWrite,
  output logic            ex_MemtoReg,
  output logic            ex_Branch,
  output logic [1:0]      forwardA,
  output logic [1:0]      forwardB,
  output logic            stall,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [CNTW-1:0] stall_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } ex_reg_t;

  ex_reg_t         ex_q, ex_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            hz;

  // Load in EX whose destination is a source of the instruction in ID.
  assign hz = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
              ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  assign stall       = hz & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_we,
                                         input logic [4:0] m_rd,
                                         input logic       w_we,
                                         input logic [4:0] w_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      sel = 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign forwardA = fwd_sel(ex_q.rs1, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd);
  assign forwardB = fwd_sel(ex_q.rs2, mem_RegWrite, mem_rd, wb_RegWrite, wb_rd);

  always_comb begin
    ex_d = '0;
    if (!(flush || stall)) begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.funct3   = id_funct3;
      ex_d.funct7   = id_funct7;
      // An invalid ID slot enters EX with every control bit cleared.
      if (id_valid) begin
        ex_d.alu_op     = id_ALUop;
        ex_d.alu_src    = id_ALUSrc;
        ex_d.mem_read   = id_MemRead;
        ex_d.mem_write  = id_MemWrite;
        ex_d.reg_write  = id_RegWrite;
        ex_d.mem_to_reg = id_MemtoReg;
        ex_d.branch     = id_Branch;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7   = ex_q.funct7;
  assign ex_ALUop    = ex_q.alu_op;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemtoReg = ex_q.mem_to_reg;
  assign ex_Branch   = ex_q.branch;
  assign stall_count = cnt_q;

endmodule
